// File: rtl/add3_sum_accum_if.sv
// Sum/convert bus between the adder stage, the accumulator and the display stage.
// The master drives sums and commands; the slave returns the accumulator and BCD result.
interface add3_sum_accum_if #(
  parameter int unsigned SUM_W      = 4,
  parameter int unsigned ACC_W      = 8,
  parameter int unsigned BCD_DIGITS = 3
);
  logic [SUM_W-1:0]        sum_in;
  logic                    sum_valid;
  logic                    sum_ready;
  logic                    clear;
  logic                    convert;
  logic [ACC_W-1:0]        acc;
  logic                    overflow;
  logic [4*BCD_DIGITS-1:0] bcd;
  logic                    bcd_valid;
  logic                    busy;

  modport master (
    output sum_in, sum_valid, clear, convert,
    input  sum_ready, acc, overflow, bcd, bcd_valid, busy
  );

  modport slave (
    input  sum_in, sum_valid, clear, convert,
    output sum_ready, acc, overflow, bcd, bcd_valid, busy
  );
endinterface

// File: rtl/add3_sum_accum.sv
// Wrapping accumulator for adder sums with sticky overflow, plus a one-bit-per-clock
// shift-add-3 converter that turns an accumulator snapshot into packed BCD.
module add3_sum_accum #(
  parameter int unsigned SUM_W      = 4,
  parameter int unsigned ACC_W      = 8,
  parameter int unsigned BCD_DIGITS = 3
) (
  input logic                clk,
  input logic                reset,
  add3_sum_accum_if.slave    bus
);

  localparam int unsigned BcdW = 4 * BCD_DIGITS;
  localparam int unsigned CntW = $clog2(ACC_W + 1);

  typedef enum logic [0:0] {StIdle, StConv} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  bin_q, bin_d;
  logic [BcdW-1:0]   scr_q, scr_d;
  logic [BcdW-1:0]   scr_adj;
  logic [BcdW-1:0]   bcd_q, bcd_d;
  logic              ovf_q, ovf_d;
  logic              bv_q, bv_d;
  logic              accept;
  logic [ACC_W:0]    sum_ext;
  logic              last_iter;

  assign accept    = bus.sum_valid && (state_q == StIdle);
  assign sum_ext   = {1'b0, acc_q} + {{(ACC_W + 1 - SUM_W){1'b0}}, bus.sum_in};
  assign last_iter = (cnt_q == CntW'(ACC_W - 1));

  // Add-3 correction applied to every digit before each shift.
  always_comb begin
    scr_adj = scr_q;
    for (int i = 0; i < int'(BCD_DIGITS); i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) begin
        scr_adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    bin_d   = bin_q;
    scr_d   = scr_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    bv_d    = bv_q;

    if (bus.clear) begin
      // Abort any conversion; the last published bcd stays on the display.
      state_d = StIdle;
      acc_d   = '0;
      ovf_d   = 1'b0;
      bv_d    = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            acc_d = sum_ext[ACC_W-1:0];
            bv_d  = 1'b0;
            if (sum_ext[ACC_W]) begin
              ovf_d = 1'b1;
            end
          end
          if (bus.convert) begin
            // Snapshot takes the post-accumulate value when both happen together.
            bin_d   = acc_d;
            scr_d   = '0;
            cnt_d   = '0;
            state_d = StConv;
          end
        end
        StConv: begin
          scr_d = {scr_adj[BcdW-2:0], bin_q[ACC_W-1]};
          bin_d = {bin_q[ACC_W-2:0], 1'b0};
          cnt_d = cnt_q + CntW'(1);
          if (last_iter) begin
            bcd_d   = scr_d;
            bv_d    = 1'b1;
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      bin_q   <= '0;
      scr_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      bv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      bv_q    <= bv_d;
    end
  end

  assign bus.sum_ready = (state_q == StIdle);
  assign bus.busy      = (state_q == StConv);
  assign bus.acc       = acc_q;
  assign bus.overflow  = ovf_q;
  assign bus.bcd       = bcd_q;
  assign bus.bcd_valid = bv_q;

endmodule

// File: tb/tb_add3_sum_accum.sv
// Bench for add3_sum_accum: directed scenarios with literal expectations, then random
// traffic, all checked each cycle against a decimal-arithmetic reference model.
module tb_add3_sum_accum;

  localparam int unsigned SUM_W      = 4;
  localparam int unsigned ACC_W      = 8;
  localparam int unsigned BCD_DIGITS = 3;
  localparam int          AccMod     = 1 << ACC_W;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  add3_sum_accum_if #(.SUM_W(SUM_W), .ACC_W(ACC_W), .BCD_DIGITS(BCD_DIGITS)) bus ();

  add3_sum_accum #(.SUM_W(SUM_W), .ACC_W(ACC_W), .BCD_DIGITS(BCD_DIGITS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  // Reference model state.
  int m_acc, m_ovf, m_bcd, m_bv, m_left, m_snap;

  function automatic int to_bcd(input int v);
    int res = 0;
    int p   = 1;
    for (int i = 0; i < int'(BCD_DIGITS); i++) begin
      res = res | (((v / p) % 10) << (4 * i));
      p   = p * 10;
    end
    return res;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Model: a conversion simply occupies ACC_W cycles, then publishes the decimal digits.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_acc <= 0; m_ovf <= 0; m_bcd <= 0; m_bv <= 0; m_left <= 0; m_snap <= 0;
    end else if (bus.clear) begin
      m_acc <= 0; m_ovf <= 0; m_bv <= 0; m_left <= 0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_bcd <= to_bcd(m_snap);
        m_bv  <= 1;
      end
    end else begin
      if (bus.sum_valid) begin
        m_acc <= (m_acc + int'(bus.sum_in)) % AccMod;
        if (m_acc + int'(bus.sum_in) >= AccMod) m_ovf <= 1;
        m_bv <= 0;
      end
      if (bus.convert) begin
        m_snap <= bus.sum_valid ? (m_acc + int'(bus.sum_in)) % AccMod : m_acc;
        m_left <= ACC_W;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en && !reset) begin
      chk("acc",       32'(bus.acc),       32'(m_acc));
      chk("overflow",  32'(bus.overflow),  32'(m_ovf));
      chk("bcd",       32'(bus.bcd),       32'(m_bcd));
      chk("bcd_valid", 32'(bus.bcd_valid), 32'(m_bv));
      chk("busy",      32'(bus.busy),      32'(m_left > 0));
      chk("sum_ready", 32'(bus.sum_ready), 32'(m_left == 0));
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic accept(input int v);
    bus.sum_valid = 1'b1;
    bus.sum_in    = SUM_W'(v);
    step();
    bus.sum_valid = 1'b0;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
  endtask

  task automatic pulse_convert();
    bus.convert = 1'b1;
    step();
    bus.convert = 1'b0;
  endtask

  // Edges after the convert-sampling edge until bcd_valid; bounded.
  task automatic wait_conv(output int n, output int busy_n);
    n = 0;
    busy_n = 0;
    while (!bus.bcd_valid && n < 20) begin
      if (bus.busy) busy_n++;
      step();
      n++;
    end
  endtask

  initial begin
    int n, bn;
    bus.sum_in = '0; bus.sum_valid = 1'b0; bus.clear = 1'b0; bus.convert = 1'b0;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_acc",  32'(bus.acc), 32'd0);
    chk("rst_bv",   32'(bus.bcd_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_bcd",  32'(bus.bcd), 32'd0);
    reset  = 1'b0;
    cmp_en = 1'b1;
    #1 chk("rst_ready", 32'(bus.sum_ready), 32'd1);
    @(negedge clk);

    // 7 + 9 + 15 = 31; bcd_valid lands on the ninth edge counting the convert edge.
    accept(7); accept(9); accept(15);
    chk("t1_acc", 32'(bus.acc), 32'd31);
    pulse_convert();
    wait_conv(n, bn);
    chk("t1_latency", 32'(n), 32'd8);
    chk("t1_busy_cycles", 32'(bn), 32'd8);
    chk("t1_bcd", 32'(bus.bcd), 32'h031);
    chk("t1_ovf", 32'(bus.overflow), 32'd0);

    // 17 x 15 = 255, then +1 wraps with overflow.
    do_clear();
    for (int i = 0; i < 17; i++) accept(15);
    chk("t2_acc", 32'(bus.acc), 32'd255);
    pulse_convert();
    wait_conv(n, bn);
    chk("t2_bcd", 32'(bus.bcd), 32'h255);
    accept(1);
    chk("t2_wrap_acc", 32'(bus.acc), 32'd0);
    chk("t2_wrap_ovf", 32'(bus.overflow), 32'd1);
    chk("t2_wrap_bv",  32'(bus.bcd_valid), 32'd0);

    // Convert and accept on the same edge: snapshot is post-accumulate.
    do_clear();
    accept(15); accept(5);
    bus.sum_valid = 1'b1; bus.sum_in = 4'd5; bus.convert = 1'b1;
    step();
    bus.sum_valid = 1'b0; bus.convert = 1'b0;
    chk("t3_acc", 32'(bus.acc), 32'd25);
    wait_conv(n, bn);
    chk("t3_bcd", 32'(bus.bcd), 32'h025);

    // Sum held during conversion waits for IDLE.
    do_clear();
    accept(15); accept(15); accept(1);
    pulse_convert();
    bus.sum_valid = 1'b1; bus.sum_in = 4'd4;
    n = 0;
    while (!bus.sum_ready && n < 20) begin
      chk("t4_acc_hold", 32'(bus.acc), 32'd31);
      step();
      n++;
    end
    chk("t4_stall_cycles", 32'(n), 32'd8);
    chk("t4_bcd", 32'(bus.bcd), 32'h031);
    chk("t4_bv",  32'(bus.bcd_valid), 32'd1);
    step();
    bus.sum_valid = 1'b0;
    chk("t4_acc", 32'(bus.acc), 32'd35);
    chk("t4_bv_stale", 32'(bus.bcd_valid), 32'd0);

    // Clear beats a same-cycle sum.
    do_clear();
    for (int i = 0; i < 17; i++) accept(15);
    accept(1);
    for (int i = 0; i < 6; i++) accept(15);
    accept(10);
    chk("t5_acc_pre", 32'(bus.acc), 32'd100);
    chk("t5_ovf_pre", 32'(bus.overflow), 32'd1);
    bus.clear = 1'b1; bus.sum_valid = 1'b1; bus.sum_in = 4'd3;
    step();
    bus.clear = 1'b0; bus.sum_valid = 1'b0;
    chk("t5_acc", 32'(bus.acc), 32'd0);
    chk("t5_ovf", 32'(bus.overflow), 32'd0);
    chk("t5_bv",  32'(bus.bcd_valid), 32'd0);

    // Async reset mid-conversion (bcd still holds 0x031 from earlier).
    for (int i = 0; i < 13; i++) accept(15);
    accept(5);
    chk("t6_acc_pre", 32'(bus.acc), 32'd200);
    pulse_convert();
    repeat (3) step();
    chk("t6_busy_pre", 32'(bus.busy), 32'd1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_acc",  32'(bus.acc), 32'd0);
    chk("t6_rst_bcd",  32'(bus.bcd), 32'd0);
    chk("t6_rst_busy", 32'(bus.busy), 32'd0);
    chk("t6_rst_rdy",  32'(bus.sum_ready), 32'd1);
    chk("t6_rst_bv",   32'(bus.bcd_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    accept(1);
    chk("t6_acc", 32'(bus.acc), 32'd1);

    // Random traffic; the per-cycle compare carries the checking.
    for (int c = 0; c < 3000; c++) begin
      bus.sum_valid = 1'($urandom_range(0, 1));
      bus.sum_in    = SUM_W'($urandom);
      bus.convert   = ($urandom_range(0, 7) == 0);
      bus.clear     = ($urandom_range(0, 63) == 0);
      step();
    end
    bus.sum_valid = 1'b0; bus.convert = 1'b0; bus.clear = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
